// File: rtl/gray_to_bin.sv
// Gray-to-binary decoder with a combinational output and a registered, valid-qualified copy.
// The registered path also flags accepted samples that are more than one Gray step apart.
module gray_to_bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] bin_q,
    output logic             out_valid,
    output logic             step_err
);

    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] diff;
    logic             multi_bit;

    logic [WIDTH-1:0] bin_reg_q, bin_reg_d;
    logic [WIDTH-1:0] last_gray_q, last_gray_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             have_last_q, have_last_d;

    // bin[i] is the XOR of gray[WIDTH-1:i]; no carry chain involved.
    always_comb begin
        bin_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_c[i] = ^(gray >> i);
        end
    end

    // More than one bit set iff clearing the lowest set bit leaves something behind.
    always_comb begin
        diff      = gray ^ last_gray_q;
        multi_bit = (diff & (diff - WIDTH'(1))) != '0;
    end

    always_comb begin
        bin_reg_d   = bin_reg_q;
        last_gray_d = last_gray_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        have_last_d = have_last_q;
        if (in_valid) begin
            bin_reg_d   = bin_c;
            last_gray_d = gray;
            valid_d     = 1'b1;
            err_d       = have_last_q && multi_bit;
            have_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_reg_q   <= '0;
            last_gray_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            have_last_q <= 1'b0;
        end else begin
            bin_reg_q   <= bin_reg_d;
            last_gray_q <= last_gray_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            have_last_q <= have_last_d;
        end
    end

    assign bin       = bin_c;
    assign bin_q     = bin_reg_q;
    assign out_valid = valid_q;
    assign step_err  = err_q;

endmodule

// File: tb/tb_gray_to_bin.sv
// Directed bench for gray_to_bin: table-driven combinational vectors plus
// hand-written registered-path, step-checker and reset sequences.
module tb_gray_to_bin;

    logic       clk;
    logic       rst_n;
    logic [7:0] gray;
    logic       in_valid;
    logic [7:0] bin;
    logic [7:0] bin_q;
    logic       out_valid;
    logic       step_err;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t tbl[11];

    gray_to_bin #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gray     (gray),
        .in_valid (in_valid),
        .bin      (bin),
        .bin_q    (bin_q),
        .out_valid(out_valid),
        .step_err (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string name, input logic [7:0] eb, input logic ev,
                             input logic ee);
        check({name, " bin_q"}, 32'(bin_q), 32'(eb));
        check({name, " out_valid"}, 32'(out_valid), 32'(ev));
        check({name, " step_err"}, 32'(step_err), 32'(ee));
    endtask

    task automatic accept(input logic [7:0] g);
        gray     = g;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        gray     = 8'h00;

        tbl[0]  = '{8'h00, 8'h00};
        tbl[1]  = '{8'h01, 8'h01};
        tbl[2]  = '{8'h03, 8'h02};
        tbl[3]  = '{8'h02, 8'h03};
        tbl[4]  = '{8'h06, 8'h04};
        tbl[5]  = '{8'h07, 8'h05};
        tbl[6]  = '{8'h05, 8'h06};
        tbl[7]  = '{8'h04, 8'h07};
        tbl[8]  = '{8'h80, 8'hFF};
        tbl[9]  = '{8'hFF, 8'hAA};
        tbl[10] = '{8'hC0, 8'h80};

        // Combinational table, applied while held in reset.
        for (int i = 0; i < 11; i++) begin
            gray = tbl[i].g;
            #1;
            check($sformatf("comb gray=%02h", tbl[i].g), 32'(bin), 32'(tbl[i].b));
        end

        // Reset with in_valid asserted for two cycles.
        gray     = 8'h55;
        in_valid = 1'b1;
        tick();
        tick();
        check_reg("reset", 8'h00, 1'b0, 1'b0);

        // First sample after reset, then step checker sequence.
        rst_n = 1'b1;
        accept(8'h03);
        check_reg("first 03", 8'h02, 1'b1, 1'b0);
        accept(8'h02);
        check_reg("step 02", 8'h03, 1'b1, 1'b0);
        accept(8'h05);
        check_reg("jump 05", 8'h06, 1'b1, 1'b1);
        accept(8'h05);
        check_reg("repeat 05", 8'h06, 1'b1, 1'b0);
        accept(8'h80);
        check_reg("jump 80", 8'hFF, 1'b1, 1'b1);
        accept(8'h00);
        check_reg("wrap 00", 8'h00, 1'b1, 1'b0);

        // Gaps: outputs hold while in_valid is low, even as gray wanders.
        accept(8'h01);
        check_reg("accept 01", 8'h01, 1'b1, 1'b0);
        in_valid = 1'b0;
        gray     = 8'h7E;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reg($sformatf("gap %0d", i), 8'h01, 1'b0, 1'b0);
        end
        // 0x03 is one step from the last accepted 0x01, not from the unqualified 0x7E.
        accept(8'h03);
        check_reg("after gap 03", 8'h02, 1'b1, 1'b0);
        accept(8'h0C);
        check_reg("jump 0C", 8'h08, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick();
        check_reg("err hold", 8'h08, 1'b0, 1'b1);

        // Mid-stream reset drops the pulse; next sample counts as the first.
        rst_n = 1'b0;
        accept(8'h0C);
        check_reg("mid reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        accept(8'hFF);
        check_reg("post reset FF", 8'hAA, 1'b1, 1'b0);
        accept(8'h00);
        check_reg("jump FF->00", 8'h00, 1'b1, 1'b1);

        // Exhaustive walk in binary order: every consecutive Gray code is one step.
        for (int b = 0; b < 256; b++) begin
            logic [7:0] bb;
            logic [7:0] g;
            bb = 8'(b);
            g  = bb ^ (bb >> 1);
            gray     = g;
            in_valid = 1'b1;
            #1;
            check($sformatf("exh bin b=%02h", bb), 32'(bin), 32'(bb));
            tick();
            check_reg($sformatf("exh reg b=%02h", bb), bb, 1'b1, 1'b0);
        end
        // 0x80 -> 0x00 closes the cycle as a legal step.
        accept(8'h00);
        check_reg("exh wrap", 8'h00, 1'b1, 1'b0);

        in_valid = 1'b0;
        tick();
        check_reg("idle end", 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
